csa_rr_share: RTL and testbench
===============================

Name: csa_rr_share

Overview:
- Round-robin arbiter and sequencer that shares one instance of the team's 32-bit carry-select adder (module CSA: a, b, cin -> sum, cout, overflow) between NREQ requesters.
- Each requester presents an operand pair over a valid/ready handshake. The block grants one requester at a time, registers the operands, captures the adder result, and returns it on a single tagged response channel with backpressure.
- It sits between datapath clients (ALU lanes, address generators) and the shared adder.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 32, operand width; fixed to the CSA width
IDW, 2, requester id width, equal to clog2(NREQ)
CNTW, 16, width of the completed-operation counter

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester accept; at most one bit high
req_a  in  NREQ*WIDTH  packed operand A; requester i uses bits [i*WIDTH +: WIDTH]
req_b  in  NREQ*WIDTH  packed operand B; same packing
req_cin  in  NREQ  per-requester carry-in
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumer ready
rsp_id  out  IDW  index of the requester that issued the operation
rsp_sum  out  WIDTH  sum
rsp_cout  out  1  carry out of the MSB
rsp_overflow  out  1  signed two's-complement overflow
ops_done  out  CNTW  count of completed response handshakes; wraps

Behaviour:
- Clocking: single clock domain. rst is synchronous and active-high and overrides all other inputs in its cycle.
- Reset values:
  - state=IDLE.
  - rr pointer = NREQ-1, so requester 0 has top priority first.
  - rsp_valid=0; rsp_id, rsp_sum, rsp_cout, rsp_overflow = 0.
  - ops_done=0; operand registers = 0.
  - req_ready=0 while rst is high.
- FSM, IDLE:
  - If any req_valid bit is set, the winner is the first set bit scanning ptr+1, ptr+2, ... modulo NREQ.
  - req_ready[winner]=1 combinationally in that cycle. It depends only on state, ptr and req_valid, never on rsp_ready.
  - On the edge: latch a/b/cin/id of the winner into the operand registers, set ptr=winner, go to EXEC.
  - If no request is valid, stay in IDLE.
- FSM, EXEC:
  - CSA is driven only from the operand registers.
  - On the edge: capture sum/cout/overflow into the response registers, set rsp_valid=1, go to HOLD.
  - req_ready=0.
- FSM, HOLD:
  - Response outputs are held stable while rsp_valid=1 and rsp_ready=0.
  - When rsp_valid and rsp_ready are both high: rsp_valid=0, ops_done+1 (wraps from all-ones to 0), go to IDLE.
  - req_ready=0 throughout HOLD.
- Latency and throughput:
  - Accept at cycle T gives rsp_valid=1 at cycle T+2.
  - Best-case throughput is one operation per 3 cycles.
  - No new request is accepted in the handshake cycle itself.
- Arithmetic, all modulo 2^WIDTH:
  - rsp_sum = a+b+cin.
  - rsp_cout = bit WIDTH of the full sum.
  - rsp_overflow = (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]).
- Fairness:
  - A requester that holds req_valid is granted within NREQ accepts.
  - Requesters may drop req_valid before being granted; no grant is issued for a dropped request.
- Request stability: requester payload need only be valid in the accept cycle.
- rsp_id: equals the requester index latched at accept.
- Reset mid-operation: rst in EXEC or HOLD drops the in-flight operation, with no response. rsp_valid=0 and ptr=NREQ-1 in the next cycle.
- Unused bits: requester indices >= NREQ never exist; no X may propagate to outputs after reset.

Test Plan:
1. Single request, req 0: a=7FFFFFFF, b=00000001, cin=0, rsp_ready=1.
   -> req_ready[0] high one cycle; rsp_valid at T+2; sum=80000000, cout=0, overflow=1, id=0; ops_done=1.
2. Single request, req 1: a=80000000, b=FFFFFFFF, cin=0.
   -> sum=7FFFFFFF, cout=1, overflow=1, id=1. Then a=FFFFFFFC, b=00000005.
   -> sum=00000001, cout=1, overflow=0.
3. Round-robin: after reset, all four req_valid held high, rsp_ready=1.
   -> grant ids 0,1,2,3,0,1 in order, one accept per 3 cycles, never two req_ready bits high.
4. Backpressure: complete a=000000A5 + b=000003E8 with rsp_ready=0 for 5 cycles.
   -> rsp_valid stays high with sum=0000048D stable; no req_ready asserted.
   -> rsp_ready=1 gives a one-cycle handshake; next accept in the following cycle.
5. Reset mid-operation: assert rst in the EXEC cycle with req 2 in flight.
   -> next cycle rsp_valid=0, ops_done=0; a subsequent simultaneous req 2 and req 0 grants req 0 first.
6. Counter wrap and zero sum: preload by running 65535 ops, then a=FFFFFC19, b=000003E7.
   -> sum=00000000, cout=1, overflow=0; ops_done wraps to 0000.

Source files
------------

// File: rtl/csa_rr_share.sv
// ============================================================================
// Module   : csa_rr_share (with the shared adder CSA)
// Purpose  : Round-robin sequencer sharing one 32-bit carry-select adder
//            between NREQ valid/ready requesters, tagged response channel.
// Revision : 1.0
// ============================================================================
`default_nettype none

module CSA #(
  parameter int WIDTH = 32,
  parameter int BLK   = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);
  localparam int NBLK = WIDTH / BLK;

  logic [NBLK:0] w_c;

  assign w_c[0] = cin;

  // Each block precomputes both carry-in cases; the incoming carry only selects.
  for (genvar g = 0; g < NBLK; g++) begin : g_blk
    logic [BLK:0] w_s0;
    logic [BLK:0] w_s1;

    assign w_s0 = {1'b0, a[g*BLK +: BLK]} + {1'b0, b[g*BLK +: BLK]};
    assign w_s1 = w_s0 + {{BLK{1'b0}}, 1'b1};
    assign sum[g*BLK +: BLK] = w_c[g] ? w_s1[BLK-1:0] : w_s0[BLK-1:0];
    assign w_c[g+1]          = w_c[g] ? w_s1[BLK]     : w_s0[BLK];
  end

  assign cout     = w_c[NBLK];
  assign overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
endmodule

module csa_rr_share #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32,
  parameter int IDW   = $clog2(NREQ),
  parameter int CNTW  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_cin,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_sum,
  output logic                  rsp_cout,
  output logic                  rsp_overflow,
  output logic [CNTW-1:0]       ops_done
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [IDW-1:0] c_ptr_rst = IDW'(NREQ - 1);

  state_t           r_state;
  logic [IDW-1:0]   r_ptr;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_cin;
  logic [IDW-1:0]   r_id;

  logic             w_any;
  logic [IDW-1:0]   w_win;
  logic [IDW-1:0]   w_idx;
  logic [WIDTH-1:0] w_a_sel;
  logic [WIDTH-1:0] w_b_sel;
  logic             w_cin_sel;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic             w_ovf;

  // Scan from farthest to nearest so the requester closest after r_ptr wins.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    w_idx = '0;
    for (int k = NREQ; k >= 1; k--) begin
      w_idx = IDW'((int'(r_ptr) + k) % NREQ);
      if (req_valid[w_idx]) begin
        w_any = 1'b1;
        w_win = w_idx;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (!rst && (r_state == IDLE) && w_any) begin
      req_ready = NREQ'(1) << w_win;
    end
  end

  assign w_a_sel   = req_a[w_win*WIDTH +: WIDTH];
  assign w_b_sel   = req_b[w_win*WIDTH +: WIDTH];
  assign w_cin_sel = req_cin[w_win];

  CSA #(
    .WIDTH(WIDTH)
  ) u_csa (
    .a       (r_a),
    .b       (r_b),
    .cin     (r_cin),
    .sum     (w_sum),
    .cout    (w_cout),
    .overflow(w_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_ptr        <= c_ptr_rst;
      r_a          <= '0;
      r_b          <= '0;
      r_cin        <= 1'b0;
      r_id         <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      rsp_sum      <= '0;
      rsp_cout     <= 1'b0;
      rsp_overflow <= 1'b0;
      ops_done     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_a     <= w_a_sel;
            r_b     <= w_b_sel;
            r_cin   <= w_cin_sel;
            r_id    <= w_win;
            r_ptr   <= w_win;
            r_state <= EXEC;
          end
        end
        EXEC: begin
          rsp_sum      <= w_sum;
          rsp_cout     <= w_cout;
          rsp_overflow <= w_ovf;
          rsp_id       <= r_id;
          rsp_valid    <= 1'b1;
          r_state      <= HOLD;
        end
        HOLD: begin
          if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
            ops_done  <= ops_done + CNTW'(1);
            r_state   <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_csa_rr_share.sv
// ============================================================================
// Module   : tb_csa_rr_share
// Purpose  : Directed scoreboard bench for csa_rr_share.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_csa_rr_share;
  localparam int NREQ = 4;
  localparam int W    = 32;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      req_valid;
  logic [3:0]      req_ready;
  logic [127:0]    req_a;
  logic [127:0]    req_b;
  logic [3:0]      req_cin;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [1:0]      rsp_id;
  logic [31:0]     rsp_sum;
  logic            rsp_cout;
  logic            rsp_overflow;
  logic [15:0]     ops_done;

  logic [3:0]      nrw_req_ready;
  logic            nrw_rsp_valid;
  logic [1:0]      nrw_rsp_id;
  logic [31:0]     nrw_rsp_sum;
  logic            nrw_rsp_cout;
  logic            nrw_rsp_overflow;
  logic [3:0]      nrw_ops_done;

  exp_t            q[$];
  exp_t            e;
  logic [15:0]     mdl_done;
  int              n_vec = 0;
  int              n_err = 0;

  always #5 clk = ~clk;

  csa_rr_share u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_overflow(rsp_overflow),
    .ops_done(ops_done)
  );

  // Narrow-counter twin on the same stimulus reaches the counter wrap quickly.
  csa_rr_share #(.CNTW(4)) u_nrw (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(nrw_req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .rsp_valid(nrw_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(nrw_rsp_id),
    .rsp_sum(nrw_rsp_sum), .rsp_cout(nrw_rsp_cout), .rsp_overflow(nrw_rsp_overflow),
    .ops_done(nrw_ops_done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input int id, input logic [31:0] a, input logic [31:0] b,
                                 input logic cin);
    logic [32:0] f;
    exp_t        x;
    f      = {1'b0, a} + {1'b0, b} + {32'd0, cin};
    x.id   = 2'(id);
    x.sum  = f[31:0];
    x.cout = f[32];
    x.ovf  = (a[31] == b[31]) && (f[31] != a[31]);
    return x;
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("ready_in_reset", req_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic issue(input int id, input logic [31:0] a, input logic [31:0] b, input logic cin);
    logic got;
    q.push_back(model(id, a, b, cin));
    @(posedge clk); #1;
    req_a[id*W +: W] = a;
    req_b[id*W +: W] = b;
    req_cin[id]      = cin;
    req_valid[id]    = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (req_ready[id]) got = 1'b1;
    end
    check("grant_seen", got, 1);
    check("grant_onehot", req_ready, 64'(1) << id);
    @(posedge clk); #1;
    req_valid[id]    = 1'b0;
    req_a[id*W +: W] = $urandom;
    req_b[id*W +: W] = $urandom;
    @(negedge clk);
    check("exec_no_valid", rsp_valid, 0);
    check("exec_no_ready", req_ready, 0);
    @(negedge clk);
    check("valid_at_t2", rsp_valid, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
    check("drain_empty", 64'(q.size()), 0);
    @(negedge clk);
    check("ops_done", ops_done, mdl_done);
    check("ops_done_narrow", nrw_ops_done, mdl_done[3:0]);
  endtask

  initial begin
    int   k;
    logic got;
    time  t_last;
    int   order[6] = '{0, 1, 2, 3, 0, 1};

    rst       = 1'b1;
    req_valid = 4'b1111;
    req_a     = '0;
    req_b     = '0;
    req_cin   = '0;
    rsp_ready = 1'b1;
    mdl_done  = '0;

    fork
      forever begin
        @(negedge clk);
        if (rst) begin
          q.delete();
          mdl_done = '0;
        end else if (rsp_valid && rsp_ready) begin
          check("rsp_expected", 64'(q.size() > 0), 1);
          if (q.size() > 0) begin
            e = q.pop_front();
            check("rsp_id", rsp_id, e.id);
            check("rsp_sum", rsp_sum, e.sum);
            check("rsp_cout", rsp_cout, e.cout);
            check("rsp_overflow", rsp_overflow, e.ovf);
            check("ops_done_pre", ops_done, mdl_done);
            mdl_done = mdl_done + 16'd1;
          end
        end
      end
    join_none

    // Reset state
    repeat (2) begin
      @(negedge clk);
      check("ready_in_reset", req_ready, 0);
    end
    @(posedge clk); #1;
    rst       = 1'b0;
    req_valid = '0;
    @(negedge clk);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rsp_sum", rsp_sum, 0);
    check("rst_rsp_cout", rsp_cout, 0);
    check("rst_rsp_ovf", rsp_overflow, 0);
    check("rst_ops_done", ops_done, 0);
    check("rst_ready", req_ready, 0);

    // Single requests
    issue(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    drain();
    issue(1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    issue(1, 32'hFFFF_FFFC, 32'h0000_0005, 1'b0);
    drain();

    // Round-robin with every requester busy
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*W +: W] = 32'h1000_0000 * i + 32'h55;
      req_b[i*W +: W] = 32'hF000_0000;
      req_cin[i]      = i[0];
    end
    for (int i = 0; i < 6; i++)
      q.push_back(model(order[i], req_a[order[i]*W +: W], req_b[order[i]*W +: W],
                        req_cin[order[i]]));
    req_valid = 4'b1111;
    k = 0;
    t_last = 0;
    for (int i = 0; i < 60 && k < 6; i++) begin
      @(negedge clk);
      if (req_ready != 4'b0000) begin
        check("rr_grant", req_ready, 64'(1) << order[k]);
        if (k > 0) check("rr_spacing", $time - t_last, 30);
        t_last = $time;
        k++;
      end
    end
    check("rr_count", k, 6);
    @(posedge clk); #1;
    req_valid = '0;
    drain();

    // Backpressure with a pending competitor
    rsp_ready = 1'b0;
    issue(0, 32'h0000_00A5, 32'h0000_03E8, 1'b0);
    req_a[3*W +: W] = 32'h11;
    req_b[3*W +: W] = 32'h22;
    req_cin[3]      = 1'b1;
    req_valid[3]    = 1'b1;
    q.push_back(model(3, 32'h11, 32'h22, 1'b1));
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("bp_valid", rsp_valid, 1);
      check("bp_sum", rsp_sum, 32'h0000_048D);
      check("bp_no_ready", req_ready, 0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("hs_no_ready", req_ready, 0);
    @(negedge clk);
    check("post_hs_valid", rsp_valid, 0);
    check("post_hs_grant", req_ready, 4'b1000);
    @(posedge clk); #1;
    req_valid = '0;
    drain();

    // Reset while req 2 is in EXEC
    @(posedge clk); #1;
    req_a[2*W +: W] = 32'h1234_5678;
    req_b[2*W +: W] = 32'h0000_0001;
    req_cin[2]      = 1'b0;
    req_valid[2]    = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (req_ready[2]) got = 1'b1;
    end
    check("r5_grant", got, 1);
    @(posedge clk); #1;
    rst             = 1'b1;
    req_a[0]        = 1'b0;
    req_a[0*W +: W] = 32'h0000_0100;
    req_b[0*W +: W] = 32'h0000_0200;
    req_cin[0]      = 1'b1;
    req_valid       = 4'b0101;
    @(negedge clk);
    check("r5_ready_in_rst", req_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    q.push_back(model(0, 32'h0000_0100, 32'h0000_0200, 1'b1));
    q.push_back(model(2, 32'h1234_5678, 32'h0000_0001, 1'b0));
    @(negedge clk);
    check("r5_rsp_valid", rsp_valid, 0);
    check("r5_ops_done", ops_done, 0);
    check("r5_first_grant", req_ready, 4'b0001);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (req_ready[2]) got = 1'b1;
    end
    check("r5_second_grant", got, 1);
    @(posedge clk); #1;
    req_valid = '0;
    drain();

    // Fill the narrow counter to 15, then the zero-sum op wraps it
    for (int i = 0; i < 13; i++) issue(i % NREQ, $urandom, $urandom, 1'(i));
    drain();
    issue(1, 32'hFFFF_FC19, 32'h0000_03E7, 1'b0);
    drain();
    check("wrap_zero", nrw_ops_done, 0);
    check("count_16", ops_done, 16);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

`default_nettype wire
